gear_nto1_base: RTL and testbench



---
 rtl/gear_pkg.sv | 40 ++++
 rtl/gear_lane_mux.sv | 41 ++++
 rtl/gear_nto1_base.sv | 164 ++++++++++++++++
 tb/tb_gear_nto1_base.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gear_pkg.sv
// ============================================================================
// gear_pkg
// ----------------------------------------------------------------------------
// Shared helpers for the gearbox family (wide-to-narrow and narrow-to-wide).
//   - gear_state_e     : two-state serializer state (EMPTY / SERIALIZING)
//   - gear_lanes()     : slices per word, widthIn / widthOut
//   - gear_idx_width() : width of a slice index able to address N lanes
//   - gear_cfg_ok()    : elaboration-time legality of a width pair
// No ports; imported with `import gear_pkg::*;`.
// ============================================================================
package gear_pkg;

    typedef enum logic {
        EMPTY       = 1'b0,
        SERIALIZING = 1'b1
    } gear_state_e;

    // Number of narrow lanes carried by one wide word.
    function automatic int gear_lanes(input int width_in, input int width_out);
        return (width_out > 0) ? (width_in / width_out) : 0;
    endfunction

    // Smallest index width that can address n lanes (at least 1 bit).
    function automatic int gear_idx_width(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

    // A width pair is legal when it divides exactly into two or more lanes.
    function automatic bit gear_cfg_ok(input int width_in, input int width_out);
        return (width_out > 0) &&
               ((width_in % width_out) == 0) &&
               ((width_in / width_out) >= 2);
    endfunction

endpackage : gear_pkg

// File: rtl/gear_lane_mux.sv
// ============================================================================
// gear_lane_mux
// ----------------------------------------------------------------------------
// Combinational N:1 slice selector. Lane i occupies bits
// [i*widthOut +: widthOut] of the buffer; lane 0 is the least significant.
//
// Parameters:
//   widthOut - slice width
//   N        - number of lanes in the buffer
// Ports:
//   buffer_i [N*widthOut-1:0] in  : wide word being serialized
//   idx_i    [IW-1:0]         in  : lane select (0 .. N-1)
//   slice_o  [widthOut-1:0]   out : selected lane
// ============================================================================
module gear_lane_mux
    import gear_pkg::*;
#(
    parameter int widthOut = 32,
    parameter int N        = 4,
    localparam int IW      = gear_idx_width(N)
) (
    input  logic [N*widthOut-1:0] buffer_i,
    input  logic [IW-1:0]         idx_i,
    output logic [widthOut-1:0]   slice_o
);

    // Compare-and-select rather than an array index so that index codes above
    // N-1 (possible in the encoding when N is not a power of two) decode to
    // zero instead of reading past the buffer.
    always_comb begin
        // NOTE: default assignment first so every path drives slice_o;
        // without it the if-chain below would infer a latch.
        slice_o = '0;
        for (int i = 0; i < N; i++) begin
            if (idx_i == IW'(i)) begin
                slice_o = buffer_i[i*widthOut +: widthOut];
            end
        end
    end

endmodule : gear_lane_mux

// File: rtl/gear_nto1_base.sv
// ============================================================================
// gear_nto1_base
// ----------------------------------------------------------------------------
// Wide-to-narrow gearbox. One widthIn-bit word accepted on the enq method is
// emitted as N = widthIn/widthOut consecutive widthOut-bit slices on the
// first/deq method pair, slice 0 (bits widthOut-1:0) first.
//
// Parameters:
//   widthIn  - input word width, integer multiple of widthOut
//   widthOut - output slice width
//   (derived) N = widthIn/widthOut >= 2, IW = index width for N lanes
//
// Ports:
//   CLK             in   clock
//   nRST            in   synchronous active-low reset
//   in_enq__ENA     in   enqueue strobe (only while in_enq__RDY)
//   in_enq_v        in   [widthIn]  word to serialize
//   in_enq__RDY     out  enqueue permitted
//   out_deq__ENA    in   dequeue strobe (only while out_deq__RDY)
//   out_deq__RDY    out  dequeue permitted
//   out_first       out  [widthOut] current slice
//   out_first__RDY  out  out_first valid
//
// Build option:
//   GEAR_NTO1_REFILL_EN - when defined, a new word may be enqueued in the same
//   cycle the last slice of the current word is dequeued, giving zero-bubble
//   output. This introduces a combinational out_deq__ENA -> in_enq__RDY path.
//   Undefined (default): enqueue only while empty, one bubble per word and no
//   ENA -> RDY combinational path.
// ============================================================================
module gear_nto1_base
    import gear_pkg::*;
#(
    parameter int widthIn  = 128,
    parameter int widthOut = 32
) (
    input  logic                CLK,
    input  logic                nRST,
    input  logic                in_enq__ENA,
    input  logic [widthIn-1:0]  in_enq_v,
    output logic                in_enq__RDY,
    input  logic                out_deq__ENA,
    output logic                out_deq__RDY,
    output logic [widthOut-1:0] out_first,
    output logic                out_first__RDY
);

    localparam int             N        = gear_lanes(widthIn, widthOut);
    localparam int             IW       = gear_idx_width(N);
    localparam logic [IW-1:0]  LAST_IDX = IW'(N - 1);

    // Reject illegal width pairs at elaboration.
    if (!gear_cfg_ok(widthIn, widthOut)) begin : g_bad_cfg
        $error("gear_nto1_base: widthIn must be a multiple of widthOut with N >= 2");
    end

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    gear_state_e          state_q;
    logic [widthIn-1:0]   buffer_q;
    logic [IW-1:0]        idx_q;
    logic [IW-1:0]        idx_d;

    logic                 valid;
    logic                 last_slice;
    logic                 enq_fire;

    assign valid      = (state_q == SERIALIZING);
    assign last_slice = (idx_q == LAST_IDX);
    assign enq_fire   = in_enq__ENA & in_enq__RDY;

    // Explicit wrap on the last slice: with N=3 a plain increment would step
    // to 3, which is a valid 2-bit code but not a lane.
    always_comb begin
        idx_d = last_slice ? '0 : (idx_q + 1'b1);
    end

    // ------------------------------------------------------------------------
    // Handshake decode
    // ------------------------------------------------------------------------
`ifdef GEAR_NTO1_REFILL_EN
    // Accept the next word while the final slice is leaving.
    assign in_enq__RDY = ~valid | (last_slice & out_deq__ENA);
`else
    assign in_enq__RDY = ~valid;
`endif

    assign out_deq__RDY   = valid;
    assign out_first__RDY = valid;

    // ------------------------------------------------------------------------
    // FSM, index counter and word buffer
    // ------------------------------------------------------------------------
    // NOTE: sequential state is updated with non-blocking assignments so all
    // registers sample pre-edge values; reset here is synchronous (sampled on
    // the clock edge only).
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q  <= EMPTY;
            // NOTE: the word buffer is cleared on reset (not only the control
            // state) so out_first reads zero after reset rather than stale data.
            buffer_q <= '0;
            idx_q    <= '0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (enq_fire) begin
                        buffer_q <= in_enq_v;
                        idx_q    <= '0;
                        state_q  <= SERIALIZING;
                    end
                end
                SERIALIZING: begin
                    if (out_deq__ENA) begin
                        // enq_fire can only be true here on the last slice of
                        // a refill build; the new word replaces the old one.
                        if (enq_fire) begin
                            buffer_q <= in_enq_v;
                            idx_q    <= '0;
                        end else begin
                            idx_q <= idx_d;
                            if (last_slice) begin
                                state_q <= EMPTY;
                            end
                        end
                    end
                end
                default: begin
                    state_q <= EMPTY;
                    idx_q   <= '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Slice selection
    // ------------------------------------------------------------------------
    gear_lane_mux #(
        .widthOut (widthOut),
        .N        (N)
    ) u_lane_mux (
        .buffer_i (buffer_q),
        .idx_i    (idx_q),
        .slice_o  (out_first)
    );

    // ------------------------------------------------------------------------
    // Protocol and invariant checks (simulation only; ignored by synthesis)
    // ------------------------------------------------------------------------
    a_enq_protocol : assert property (@(posedge CLK) disable iff (!nRST)
        in_enq__ENA |-> in_enq__RDY)
        else $error("gear_nto1_base: in_enq__ENA asserted while not ready");

    a_deq_protocol : assert property (@(posedge CLK) disable iff (!nRST)
        out_deq__ENA |-> out_deq__RDY)
        else $error("gear_nto1_base: out_deq__ENA asserted while not ready");

    a_idx_bound : assert property (@(posedge CLK) disable iff (!nRST)
        idx_q <= LAST_IDX)
        else $error("gear_nto1_base: slice index beyond last lane");

endmodule : gear_nto1_base

// File: tb/tb_gear_nto1_base.sv
// ============================================================================
// tb_gear_nto1_base
// ----------------------------------------------------------------------------
// Self-checking bench for gear_nto1_base. Two instances: 128/32 (N=4) and
// 96/32 (N=3). The reference model for the N=4 instance is a queue of pending
// slices: an accepted word pushes its N slices, a dequeue pops the front.
// Build option GEAR_NTO1_REFILL_EN selects the zero-bubble expectations.
// ============================================================================
module tb_gear_nto1_base;

`ifdef GEAR_NTO1_REFILL_EN
    localparam bit REFILL = 1'b1;
`else
    localparam bit REFILL = 1'b0;
`endif

    localparam int WI  = 128;
    localparam int WO  = 32;
    localparam int NA  = WI / WO;
    localparam int WI3 = 96;
    localparam int NB  = WI3 / WO;

    logic            clk;
    logic            n_rst;

    // N=4 instance
    logic            a_enq;
    logic [WI-1:0]   a_v;
    logic            a_enq_rdy;
    logic            a_deq;
    logic            a_deq_rdy;
    logic [WO-1:0]   a_first;
    logic            a_first_rdy;

    // N=3 instance
    logic            b_enq;
    logic [WI3-1:0]  b_v;
    logic            b_enq_rdy;
    logic            b_deq;
    logic            b_deq_rdy;
    logic [WO-1:0]   b_first;
    logic            b_first_rdy;

    int vectors    = 0;
    int miscompares = 0;

    logic [WO-1:0] q[$];   // pending slices of the N=4 instance

    gear_nto1_base #(.widthIn(WI), .widthOut(WO)) dut (
        .CLK            (clk),
        .nRST           (n_rst),
        .in_enq__ENA    (a_enq),
        .in_enq_v       (a_v),
        .in_enq__RDY    (a_enq_rdy),
        .out_deq__ENA   (a_deq),
        .out_deq__RDY   (a_deq_rdy),
        .out_first      (a_first),
        .out_first__RDY (a_first_rdy)
    );

    gear_nto1_base #(.widthIn(WI3), .widthOut(WO)) dut3 (
        .CLK            (clk),
        .nRST           (n_rst),
        .in_enq__ENA    (b_enq),
        .in_enq_v       (b_v),
        .in_enq__RDY    (b_enq_rdy),
        .out_deq__ENA   (b_deq),
        .out_deq__RDY   (b_deq_rdy),
        .out_first      (b_first),
        .out_first__RDY (b_first_rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // One cycle of the N=4 instance against the queue model. Called right
    // after a falling edge; returns right after the next falling edge.
    task automatic model_cycle(input string tag, input bit want_deq, input bit want_enq,
                               input logic [WI-1:0] w, output bit enq_taken,
                               output bit deq_taken, output logic [WO-1:0] obs_first);
        bit exp_valid;
        bit exp_rdy;
        exp_valid = (q.size() > 0);
        a_deq     = want_deq && exp_valid;
        exp_rdy   = !exp_valid || (REFILL && q.size() == 1 && a_deq);
        a_enq     = want_enq && exp_rdy;
        a_v       = w;
        #1;
        obs_first = a_first;
        vectors++;
        if (a_first_rdy !== exp_valid) begin
            miscompares++;
            $display("FAIL %s first_rdy: got %b want %b", tag, a_first_rdy, exp_valid);
        end
        vectors++;
        if (a_deq_rdy !== exp_valid) begin
            miscompares++;
            $display("FAIL %s deq_rdy: got %b want %b", tag, a_deq_rdy, exp_valid);
        end
        vectors++;
        if (a_enq_rdy !== exp_rdy) begin
            miscompares++;
            $display("FAIL %s enq_rdy: got %b want %b", tag, a_enq_rdy, exp_rdy);
        end
        if (exp_valid) begin
            vectors++;
            if (a_first !== q[0]) begin
                miscompares++;
                $display("FAIL %s first: got %h want %h", tag, a_first, q[0]);
            end
        end
        enq_taken = a_enq;
        deq_taken = a_deq;
        @(posedge clk);
        if (a_deq) void'(q.pop_front());
        if (a_enq) for (int i = 0; i < NA; i++) q.push_back(w[i*WO +: WO]);
        @(negedge clk);
        a_enq = 1'b0;
        a_deq = 1'b0;
    endtask

    task automatic apply_reset(input int cycles);
        @(negedge clk);
        n_rst = 1'b0;
        a_enq = 1'b0; a_deq = 1'b0;
        b_enq = 1'b0; b_deq = 1'b0;
        repeat (cycles) @(posedge clk);
        @(negedge clk);
        n_rst = 1'b1;
        q.delete();
    endtask

    task automatic test_reset();
        apply_reset(2);
        #1;
        vectors++;
        if (a_enq_rdy !== 1'b1) begin miscompares++; $display("FAIL reset enq_rdy: got %b want 1", a_enq_rdy); end
        vectors++;
        if (a_first_rdy !== 1'b0) begin miscompares++; $display("FAIL reset first_rdy: got %b want 0", a_first_rdy); end
        vectors++;
        if (a_deq_rdy !== 1'b0) begin miscompares++; $display("FAIL reset deq_rdy: got %b want 0", a_deq_rdy); end
        vectors++;
        if (a_first !== '0) begin miscompares++; $display("FAIL reset first: got %h want 0", a_first); end
        vectors++;
        if (b_enq_rdy !== 1'b1 || b_first_rdy !== 1'b0 || b_first !== '0) begin
            miscompares++;
            $display("FAIL reset n3: enq_rdy %b first_rdy %b first %h want 1 0 0",
                     b_enq_rdy, b_first_rdy, b_first);
        end
        @(negedge clk);
    endtask

    task automatic test_single_word();
        logic [WI-1:0] w;
        logic [WO-1:0] exp_s [NA];
        logic [WO-1:0] obs;
        bit et, dt;
        w = 128'h44444444_33333333_22222222_11111111;
        exp_s = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
        model_cycle("single_enq", 1'b0, 1'b1, w, et, dt, obs);
        for (int i = 0; i < NA; i++) begin
            model_cycle("single_deq", 1'b1, 1'b0, '0, et, dt, obs);
            vectors++;
            if (obs !== exp_s[i]) begin
                miscompares++;
                $display("FAIL single slice%0d: got %h want %h", i, obs, exp_s[i]);
            end
        end
        model_cycle("single_idle", 1'b0, 1'b0, '0, et, dt, obs);
    endtask

    task automatic test_backpressure();
        logic [WI-1:0] w;
        logic [WO-1:0] obs;
        bit et, dt;
        w = 128'h44444444_33333333_22222222_11111111;
        model_cycle("bp_enq", 1'b0, 1'b1, w, et, dt, obs);
        for (int c = 0; c < 5; c++) begin
            model_cycle("bp_hold", 1'b0, 1'b1, ~w, et, dt, obs);
            vectors++;
            if (obs !== 32'h11111111 || et) begin
                miscompares++;
                $display("FAIL bp_hold cycle%0d: first %h enq_taken %b want 11111111 0", c, obs, et);
            end
        end
        for (int i = 0; i < NA; i++) model_cycle("bp_resume", 1'b1, 1'b0, '0, et, dt, obs);
        model_cycle("bp_idle", 1'b0, 1'b0, '0, et, dt, obs);
    endtask

    task automatic test_back_to_back();
        logic [WI-1:0] words [2];
        logic [WO-1:0] obs;
        bit et, dt;
        int sent, pops, first_pop, last_pop, want_span;
        words[0] = {$urandom, $urandom, $urandom, $urandom};
        words[1] = {$urandom, $urandom, $urandom, $urandom};
        sent = 0; pops = 0; first_pop = -1; last_pop = -1;
        for (int cyc = 0; cyc < 40 && pops < 2*NA; cyc++) begin
            model_cycle("b2b", 1'b1, sent < 2, words[sent < 2 ? sent : 1], et, dt, obs);
            if (et) sent++;
            if (dt) begin
                if (first_pop < 0) first_pop = cyc;
                last_pop = cyc;
                pops++;
            end
        end
        want_span = REFILL ? 2*NA : 2*NA + 1;
        vectors++;
        if (pops !== 2*NA) begin
            miscompares++;
            $display("FAIL b2b slices: got %0d want %0d", pops, 2*NA);
        end
        vectors++;
        if (last_pop - first_pop + 1 !== want_span) begin
            miscompares++;
            $display("FAIL b2b span: got %0d cycles want %0d", last_pop - first_pop + 1, want_span);
        end
        model_cycle("b2b_idle", 1'b0, 1'b0, '0, et, dt, obs);
    endtask

    task automatic test_reset_mid_word();
        logic [WI-1:0] w;
        logic [WO-1:0] obs;
        bit et, dt;
        w = {$urandom, $urandom, $urandom, $urandom};
        model_cycle("mid_enq", 1'b0, 1'b1, w, et, dt, obs);
        model_cycle("mid_deq", 1'b1, 1'b0, '0, et, dt, obs);
        model_cycle("mid_deq", 1'b1, 1'b0, '0, et, dt, obs);
        n_rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #1;
        vectors++;
        if (a_first_rdy !== 1'b0 || a_enq_rdy !== 1'b1 || a_first !== '0) begin
            miscompares++;
            $display("FAIL mid_reset: first_rdy %b enq_rdy %b first %h want 0 1 0",
                     a_first_rdy, a_enq_rdy, a_first);
        end
        n_rst = 1'b1;
        q.delete();
        @(negedge clk);
        w = {$urandom, $urandom, $urandom, $urandom};
        model_cycle("mid_new_enq", 1'b0, 1'b1, w, et, dt, obs);
        model_cycle("mid_new_deq", 1'b1, 1'b0, '0, et, dt, obs);
        vectors++;
        if (obs !== w[WO-1:0]) begin
            miscompares++;
            $display("FAIL mid_new slice0: got %h want %h", obs, w[WO-1:0]);
        end
        for (int i = 1; i < NA; i++) model_cycle("mid_new_deq", 1'b1, 1'b0, '0, et, dt, obs);
    endtask

    task automatic test_random();
        logic [WO-1:0] obs;
        bit et, dt;
        for (int c = 0; c < 400; c++) begin
            model_cycle("random", $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                        {$urandom, $urandom, $urandom, $urandom}, et, dt, obs);
        end
        while (q.size() > 0) model_cycle("random_drain", 1'b1, 1'b0, '0, et, dt, obs);
    endtask

    task automatic test_non_pow2();
        logic [WI3-1:0] w;
        for (int k = 0; k < 2; k++) begin
            w = (k == 0) ? 96'hCCCCCCCC_BBBBBBBB_AAAAAAAA : {$urandom, $urandom, $urandom};
            b_enq = 1'b1;
            b_v   = w;
            #1;
            vectors++;
            if (b_enq_rdy !== 1'b1) begin miscompares++; $display("FAIL n3 enq_rdy: got %b want 1", b_enq_rdy); end
            @(posedge clk);
            @(negedge clk);
            b_enq = 1'b0;
            for (int i = 0; i < NB; i++) begin
                b_deq = 1'b1;
                #1;
                vectors++;
                if (b_first_rdy !== 1'b1 || b_first !== w[i*WO +: WO]) begin
                    miscompares++;
                    $display("FAIL n3 word%0d slice%0d: rdy %b first %h want 1 %h",
                             k, i, b_first_rdy, b_first, w[i*WO +: WO]);
                end
                @(posedge clk);
                @(negedge clk);
            end
            b_deq = 1'b0;
            #1;
            vectors++;
            if (b_first_rdy !== 1'b0 || b_enq_rdy !== 1'b1) begin
                miscompares++;
                $display("FAIL n3 drained: first_rdy %b enq_rdy %b want 0 1", b_first_rdy, b_enq_rdy);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        n_rst = 1'b0;
        a_enq = 1'b0; a_deq = 1'b0; a_v = '0;
        b_enq = 1'b0; b_deq = 1'b0; b_v = '0;
        test_reset();
        test_single_word();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_word();
        test_non_pow2();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_gear_nto1_base
